// File: rtl/pipe_chunk_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit ripple segment per stage, carries registered between
// stages. Define PIPE_CHUNK_ADDER_SAT_EN for unsigned saturation of o_Sum in the output register.
module pipe_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_ovf
);
    localparam int unsigned SafeChunk = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned STAGES    = (WIDTH / SafeChunk == 0) ? 1 : WIDTH / SafeChunk;
    localparam bit          BadCfg    = (CHUNK == 0) || ((WIDTH % SafeChunk) != 0);

    if (BadCfg) begin : g_bad_cfg
        $error("pipe_chunk_adder: WIDTH must be a nonzero integer multiple of CHUNK");
    end

    logic                 adv;
    logic [STAGES-1:0]    vld_q, vld_d, vld_in;
    logic [STAGES-1:0]    c_q, c_d, c_in;
    logic [WIDTH-1:0]     a_q   [STAGES];
    logic [WIDTH-1:0]     a_d   [STAGES];
    logic [WIDTH-1:0]     a_in  [STAGES];
    logic [WIDTH-1:0]     b_q   [STAGES];
    logic [WIDTH-1:0]     b_d   [STAGES];
    logic [WIDTH-1:0]     b_in  [STAGES];
    logic [WIDTH-1:0]     s_q   [STAGES];
    logic [WIDTH-1:0]     s_d   [STAGES];
    logic [WIDTH-1:0]     s_in  [STAGES];
    logic                 ovf_q, ovf_d;
`ifdef PIPE_CHUNK_ADDER_SAT_EN
    logic                 sub_q [STAGES];
    logic                 sub_d [STAGES];
    logic                 sub_in[STAGES];
`endif

    assign adv     = i_ready | ~vld_q[STAGES-1];
    assign o_ready = adv;
    assign o_valid = vld_q[STAGES-1];
    assign o_Sum   = s_q[STAGES-1];
    assign o_Cout  = c_q[STAGES-1];
    assign o_ovf   = ovf_q;

    // Stage inputs: stage 0 from the ports, stage k from register level k-1.
    always_comb begin
        vld_in[0] = i_valid;
        a_in[0]   = i_A;
        b_in[0]   = i_sub ? ~i_B : i_B;
        s_in[0]   = '0;
        c_in[0]   = i_sub | i_Cin;
`ifdef PIPE_CHUNK_ADDER_SAT_EN
        sub_in[0] = i_sub;
`endif
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
`ifdef PIPE_CHUNK_ADDER_SAT_EN
            sub_in[k] = sub_q[k-1];
`endif
        end
    end

    always_comb begin
        logic c;
        logic c_msb;
        logic ab_x;
        c     = 1'b0;
        c_msb = 1'b0;
        ab_x  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = vld_in[k];
            a_d[k]   = a_in[k];
            b_d[k]   = b_in[k];
            s_d[k]   = s_in[k];
            c        = c_in[k];
            for (int j = 0; j < CHUNK; j++) begin
                c_msb = c;
                ab_x  = a_in[k][k*CHUNK+j] ^ b_in[k][k*CHUNK+j];
                s_d[k][k*CHUNK+j] = ab_x ^ c;
                c = (a_in[k][k*CHUNK+j] & b_in[k][k*CHUNK+j]) | (c & ab_x);
            end
            c_d[k] = c;
`ifdef PIPE_CHUNK_ADDER_SAT_EN
            sub_d[k] = sub_in[k];
`endif
        end
        // After the loop c_msb/c are the carry into and out of the MSB of the last stage.
        ovf_d = c_msb ^ c;
`ifdef PIPE_CHUNK_ADDER_SAT_EN
        if (sub_in[STAGES-1] && !c_d[STAGES-1]) begin
            s_d[STAGES-1] = '0;
        end else if (!sub_in[STAGES-1] && c_d[STAGES-1]) begin
            s_d[STAGES-1] = '1;
        end
`endif
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef PIPE_CHUNK_ADDER_SAT_EN
                sub_q[k] <= 1'b0;
`endif
            end
        end else if (adv) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
`ifdef PIPE_CHUNK_ADDER_SAT_EN
                sub_q[k] <= sub_d[k];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipe_chunk_adder.sv
// Scoreboard bench for pipe_chunk_adder: a 4-stage instance and a single-stage (CHUNK=16) instance.
`timescale 1ns/1ps
module tb_pipe_chunk_adder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0, rdy_o, ovld, ordy = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, sub = 1'b0, cout, ovf;
    logic        vld1 = 1'b0, rdy1_o, ovld1, ordy1 = 1'b1;
    logic [15:0] a1 = '0, b1 = '0, sum1;
    logic        cin1 = 1'b0, sub1 = 1'b0, cout1, ovf1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [17:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .s_clk(clk), .s_rst(rst), .i_valid(vld), .o_ready(rdy_o), .i_A(a), .i_B(b),
        .i_Cin(cin), .i_sub(sub), .o_valid(ovld), .i_ready(ordy), .o_Sum(sum),
        .o_Cout(cout), .o_ovf(ovf)
    );

    pipe_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .s_clk(clk), .s_rst(rst), .i_valid(vld1), .o_ready(rdy1_o), .i_A(a1), .i_B(b1),
        .i_Cin(cin1), .i_sub(sub1), .o_valid(ovld1), .i_ready(ordy1), .o_Sum(sum1),
        .o_Cout(cout1), .o_ovf(ovf1)
    );

    // Reference: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic cv, input logic sv);
        logic [15:0] bp;
        logic [16:0] full;
        logic [15:0] res;
        logic        o;
        bp   = sv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bp} + {16'd0, (sv ? 1'b1 : cv)};
        o    = (av[15] == bp[15]) && (full[15] != av[15]);
        res  = full[15:0];
`ifdef PIPE_CHUNK_ADDER_SAT_EN
        if (!sv && full[16]) res = 16'hFFFF;
        if (sv && !full[16]) res = 16'h0000;
`endif
        return {o, full[16], res};
    endfunction

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input logic r);
        @(negedge clk);
        vld  = v;
        a    = av;
        b    = bv;
        cin  = cv;
        sub  = sv;
        ordy = r;
        #1;
    endtask

    task automatic commit();
        if (ovld && ordy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (vld && rdy_o && !rst) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ovld !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b, want 0/0000/0/0",
                     ovld, sum, cout, ovf);
        end
        checks++;
        if (ovld1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_s1: got %b, want 0", ovld1);
        end
        @(negedge clk);
        rst  = 1'b0;
        ordy = 1'b0;
        #1;
        checks++;
        if (rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", rdy_o);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        va[0] = 16'h0FFF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = 16'h1234; vb[2] = 16'h1235; vc[2] = 1'b0; vs[2] = 1'b1;
        va[3] = 16'h7FFF; vb[3] = 16'hFFFF; vc[3] = 1'b0; vs[3] = 1'b1;
        for (int i = 4; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom);
            vs[i] = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            for (int t = 0; t < LAT + 2; t++) begin
                if (t == 0) drive(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1);
                else        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
                if (ovld) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL basic_unexpected: got sum=%h, want no result", sum);
                    end else begin
                        if ({ovf, cout, sum} !== exp_q[0]) begin
                            errors++;
                            $display("FAIL basic_value[%0d]: got o=%b c=%b sum=%h, want %h",
                                     i, ovf, cout, sum, exp_q[0]);
                        end
                        checks++;
                        if (cyc != acc_q[0] + LAT) begin
                            errors++;
                            $display("FAIL basic_latency[%0d]: got %0d, want %0d",
                                     i, cyc - acc_q[0], LAT);
                        end
                    end
                end
                commit();
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int          n = 1;
        int          got = 0;
        logic        hold = 1'b0;
        logic [17:0] held = '0;
        logic        acc;
        for (int t = 0; t < 80 && (n <= 8 || exp_q.size() > 0); t++) begin
            drive(n <= 8, 16'(n), 16'(n << 8), 1'b0, 1'b0, (t % 3) == 0);
            if (hold) begin
                checks++;
                if (!ovld || {ovf, cout, sum} !== held) begin
                    errors++;
                    $display("FAIL b2b_hold: got v=%b %h, want v=1 %h",
                             ovld, {ovf, cout, sum}, held);
                end
            end
            if (ovld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got sum=%h, want no result", sum);
                end else if ({ovf, cout, sum} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_value: got %h, want %h", {ovf, cout, sum}, exp_q[0]);
                end
                if (ordy) got++;
            end
            hold = ovld && !ordy;
            held = {ovf, cout, sum};
            acc  = vld && rdy_o;
            commit();
            if (acc) n++;
        end
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results (%0d pending), want 8 (0)",
                     got, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h10 + i), 16'h0020, 1'b0, 1'b0, 1'b1);
            commit();
        end
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ovld !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush: got o_valid=%b, want 0", ovld);
        end
        for (int t = 0; t < 14; t++) begin
            if (t == 6) drive(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
            else        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (ovld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_stale: got sum=%h after reset, want no result", sum);
                end else begin
                    if ({ovf, cout, sum} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rst_fresh_value: got %h, want %h",
                                 {ovf, cout, sum}, exp_q[0]);
                    end
                    checks++;
                    if (cyc != acc_q[0] + LAT) begin
                        errors++;
                        $display("FAIL rst_fresh_latency: got %0d, want %0d",
                                 cyc - acc_q[0], LAT);
                    end
                end
            end
            commit();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_fresh_missing: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_single_stage();
        logic [17:0] q1[$];
        int          t_acc;
        // Two beats back-to-back, then a bubble.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            vld1 = (t < 2);
            a1   = (t == 0) ? 16'h8000 : 16'h0005;
            b1   = (t == 0) ? 16'h8000 : 16'h0007;
            sub1 = (t == 1);
            cin1 = 1'b0;
            #1;
            if (t > 0) begin
                checks++;
                if (!ovld1 || q1.size() == 0 || {ovf1, cout1, sum1} !== q1[0]
                    || cyc != t_acc + 1) begin
                    errors++;
                    $display("FAIL s1_result[%0d]: got v=%b %h at +%0d, want v=1 %h at +1",
                             t, ovld1, {ovf1, cout1, sum1}, cyc - t_acc,
                             (q1.size() > 0) ? q1[0] : 18'h0);
                end
                if (q1.size() > 0) void'(q1.pop_front());
            end
            if (vld1 && rdy1_o) begin
                q1.push_back(model(a1, b1, cin1, sub1));
                t_acc = cyc;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (ovld1 !== 1'b0) begin
            errors++;
            $display("FAIL s1_bubble: got o_valid=%b, want 0", ovld1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_midflight();
        test_single_stage();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_chunk_adder.md
Name: pipe_chunk_adder

Overview:
- Parametrised, pipelined, carry-chained adder/subtractor for the AttnCalc accumulation paths.
- Splits a WIDTH-bit add into STAGES = WIDTH/CHUNK ripple segments. Each segment is a chain of full-adder cells, and the carry between segments is registered.
- Streams one operation per cycle, with valid/ready handshakes on input and output.
- Replaces single-bit full-adder chains wherever wide sums would break timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of CHUNK, otherwise elaboration fails via a generate-time error.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

Ports:
- s_clk  input  1  system clock; all state updates on the rising edge.
- s_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_A  input  WIDTH  operand A, unsigned.
- i_B  input  WIDTH  operand B, unsigned.
- i_Cin  input  1  carry-in; ignored when i_sub=1.
- i_sub  input  1  1 = compute A - B as A + ~B + 1.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result.
- o_Sum  output  WIDTH  result.
- o_Cout  output  1  final carry-out; for subtract, 1 = no borrow (A >= B).
- o_ovf  output  1  signed two's-complement overflow of the operation.

Behaviour:
- Single clock s_clk. s_rst is synchronous, active-high.
- Reset: all valid bits, carry registers and skew registers clear. o_valid=0, o_Sum=0, o_Cout=0, o_ovf=0. o_ready=1 in the first cycle after reset deasserts.
- Pipeline advance: adv = i_ready | ~o_valid. o_ready = adv, which is combinational from i_ready and o_valid; this is the only comb path in to out.
- When adv=0, every pipeline register holds, including data, carries and valids.
- Input accept: a beat is accepted when i_valid & o_ready. When adv=1 and i_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not compressed; the fixed slot structure is kept.
- Stage k (0..STAGES-1) adds operand chunk k. Each chunk is A[k*CHUNK +: CHUNK] and B'[k*CHUNK +: CHUNK], where B' = i_sub ? ~B : B.
- The carry into stage k is the registered carry from stage k-1. For stage 0, the carry is (i_sub ? 1 : i_Cin).
- Operand chunk k is delayed k cycles through skew registers before it is added.
- Result chunk k is delayed STAGES-1-k cycles after it is computed, so all chunks align at the output register.
- Latency: a beat accepted at edge t appears with o_valid=1 after edge t+STAGES, provided adv stays 1. Each stall cycle adds one.
- Throughput: one beat per cycle while i_ready=1.
- o_Cout is the carry out of the top chunk.
- o_ovf = carry into the MSB XOR carry out of the MSB. It is computed in the last stage and registered with the result.
- Output hold: while o_valid=1 and i_ready=0, o_Sum, o_Cout and o_ovf stay stable and unchanged.
- Ordering: results leave in acceptance order; no beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded. No stale result appears after reset.
- Boundary, STAGES=1: the block degenerates to a registered adder with latency 1 and no skew registers.
- Simultaneous events: a new input can be accepted in the same cycle the output is consumed; both happen on the same edge.

Optional Feature:
- Macro: PIPE_CHUNK_ADDER_SAT_EN.
- Defined: the output is unsigned-saturating.
  - Add with o_Cout=1: o_Sum is forced to all-ones.
  - Subtract with o_Cout=0 (borrow): o_Sum is forced to 0.
  - o_Cout and o_ovf still report the raw, pre-saturation flags.
  - Saturation is applied in the final output register; latency is unchanged.
- Undefined: o_Sum is the modulo-2^WIDTH result. No saturation logic is instantiated.

Test Plan:
1. WIDTH=16, CHUNK=4, i_ready=1. A=0x0FFF, B=0x0001, Cin=0, add -> exactly 4 cycles after accept: o_Sum=0x1000, o_Cout=0, o_ovf=0.
2. A=0xFFFF, B=0x0001, add -> o_Sum=0x0000, o_Cout=1. With PIPE_CHUNK_ADDER_SAT_EN defined -> o_Sum=0xFFFF, o_Cout=1.
3. A=0x1234, B=0x1235, i_sub=1 -> o_Sum=0xFFFF, o_Cout=0. With SAT_EN -> o_Sum=0x0000. A=0x7FFF, B=0xFFFF, sub -> o_Sum=0x8000, o_ovf=1.
4. Stream 8 back-to-back beats (A=n, B=0x0100·n, n=1..8), i_ready toggled 1,0,0,1,... -> 8 results in order, each n+0x0100·n. Held values stay stable during stalls; no drop or duplicate.
5. Assert s_rst for 1 cycle with 3 beats in flight -> o_valid=0 on the next cycle and no result from those beats ever appears. A fresh beat 0x0002+0x0003 afterwards -> 0x0005 after 4 cycles.
6. CHUNK=16 (STAGES=1): A=0x8000, B=0x8000 -> o_Sum=0x0000, o_Cout=1, o_ovf=1, latency 1 cycle.
